uart_mem_initiator: RTL and testbench

// - Bus initiator for the UART register memory interface.
// - Accepts single read/write commands on a valid/ready channel and issues exactly one mem_we/mem_re pulse per attempt.
// - Captures the same-cycle response and returns it on a valid/ready response channel.
// - Sits between the CPU/debug fabric and the UART register block; optionally retries SLVERR (e.g. TX FIFO full, RX FIFO empty).

---
 rtl/uart_mem_initiator_if.sv | 34 +++
 rtl/uart_mem_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_uart_mem_initiator.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_initiator_if.sv
// Command/response channel bundle between the CPU/debug fabric and
// uart_mem_initiator.
//   master modport : fabric side (drives commands, accepts responses)
//   slave modport  : initiator side (accepts commands, returns responses)
// Signal names keep the initiator-relative _i/_o suffixes of the
// original flat port list.
interface uart_mem_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_write_i;
  logic [ADDR_WIDTH-1:0]   cmd_addr_i;
  logic [DATA_WIDTH-1:0]   cmd_wdata_i;
  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_rdata_o;
  logic [1:0]              rsp_resp_o;
  logic [3:0]              rsp_retries_o;

  modport master (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
    output rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_resp_o, rsp_retries_o
  );

  modport slave (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
    input  rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_resp_o, rsp_retries_o
  );
endinterface

// File: rtl/uart_mem_initiator.sv
// uart_mem_initiator: bus initiator for the UART register memory interface.
// Takes one read/write command at a time, issues exactly one mem_we_o or
// mem_re_o pulse per attempt, captures the same-cycle response and returns
// it on the response channel.
//
// Optional feature: define UART_MEM_INITIATOR_RETRY_EN to retry SLVERR
// responses up to MAX_RETRY times with BACKOFF_CYCLES idle cycles between
// attempts. Without it SLVERR is reported immediately and rsp_retries_o=0.
//
// Ports:
//   clk_i, arst_ni    clock, asynchronous active-low reset
//   bus (slave)       cmd_* command channel, rsp_* response channel
//   mem_we_o/mem_waddr_o/mem_wdata_o/mem_wstrb_o, mem_wresp_i   write side
//   mem_re_o/mem_raddr_o, mem_rdata_i/mem_rresp_i               read side
module uart_mem_initiator #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_RETRY      = 15,
  parameter int unsigned BACKOFF_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  uart_mem_initiator_if.slave     bus,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_waddr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic [1:0]              mem_wresp_i,
  output logic                    mem_re_o,
  output logic [ADDR_WIDTH-1:0]   mem_raddr_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic [1:0]              mem_rresp_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
`ifdef UART_MEM_INITIATOR_RETRY_EN
    S_BACKOFF = 2'd2,
`endif
    S_RESP    = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_resp;

  logic                    r_mem_we;
  logic                    r_mem_re;
  logic [ADDR_WIDTH-1:0]   r_mem_waddr;
  logic [ADDR_WIDTH-1:0]   r_mem_raddr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [STRB_WIDTH-1:0]   r_mem_wstrb;

  logic                    w_cmd_hs;
  logic                    w_retry;
  logic [1:0]              w_access_resp;
  logic                    w_ok;
  logic                    w_go_access;
  logic                    w_wr_sel;
  logic [ADDR_WIDTH-1:0]   w_addr_sel;
  logic [DATA_WIDTH-1:0]   w_wdata_sel;
  logic [STRB_WIDTH-1:0]   w_wstrb_sel;

`ifdef UART_MEM_INITIATOR_RETRY_EN
  localparam int unsigned BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam logic [3:0]    LP_MAX_RETRY    = 4'(MAX_RETRY);
  localparam logic [BW-1:0] LP_BACKOFF_LAST = BW'(BACKOFF_CYCLES - 1);

  logic [3:0]    r_retries;
  logic [BW-1:0] r_backoff;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(MAX_RETRY), 32'(BACKOFF_CYCLES)};
`endif

  // Next state and attempt outcome
  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_hs      = 1'b0;
    w_retry       = 1'b0;
    w_access_resp = r_write ? mem_wresp_i : mem_rresp_i;
    w_ok          = (w_access_resp == 2'b00);
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          w_cmd_hs    = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
`ifdef UART_MEM_INITIATOR_RETRY_EN
        if (!w_ok && (r_retries < LP_MAX_RETRY)) begin
          w_retry     = 1'b1;
          w_state_nxt = S_BACKOFF;
        end else begin
          w_state_nxt = S_RESP;
        end
`else
        w_state_nxt = S_RESP;
`endif
      end
`ifdef UART_MEM_INITIATOR_RETRY_EN
      S_BACKOFF: begin
        if (r_backoff == '0) w_state_nxt = S_ACCESS;
      end
`endif
      S_RESP: begin
        if (bus.rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The mem strobes are registered: they are loaded on the edge entering
  // ACCESS, so the command fields come straight from the bus on the
  // handshake edge and from the latched copy when re-entering from BACKOFF.
  assign w_go_access = (w_state_nxt == S_ACCESS);
  assign w_wr_sel    = w_cmd_hs ? bus.cmd_write_i : r_write;
  assign w_addr_sel  = w_cmd_hs ? bus.cmd_addr_i  : r_addr;
  assign w_wdata_sel = w_cmd_hs ? bus.cmd_wdata_i : r_wdata;
  assign w_wstrb_sel = w_cmd_hs ? bus.cmd_wstrb_i : r_wstrb;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_resp      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_raddr <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
`ifdef UART_MEM_INITIATOR_RETRY_EN
      r_retries   <= '0;
      r_backoff   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;

      if (w_cmd_hs) begin
        r_write <= bus.cmd_write_i;
        r_addr  <= bus.cmd_addr_i;
        r_wdata <= bus.cmd_wdata_i;
        r_wstrb <= bus.cmd_wstrb_i;
      end

      // Final attempt: keep read data only for an OKAY read
      if ((r_state == S_ACCESS) && !w_retry) begin
        r_rdata <= (w_ok && !r_write) ? mem_rdata_i : '0;
        r_resp  <= w_access_resp;
      end

      r_mem_we    <= w_go_access &  w_wr_sel;
      r_mem_re    <= w_go_access & ~w_wr_sel;
      r_mem_waddr <= (w_go_access &  w_wr_sel) ? w_addr_sel  : '0;
      r_mem_wdata <= (w_go_access &  w_wr_sel) ? w_wdata_sel : '0;
      r_mem_wstrb <= (w_go_access &  w_wr_sel) ? w_wstrb_sel : '0;
      r_mem_raddr <= (w_go_access & ~w_wr_sel) ? w_addr_sel  : '0;

`ifdef UART_MEM_INITIATOR_RETRY_EN
      if (w_cmd_hs) begin
        r_retries <= '0;
      end else if (w_retry) begin
        r_retries <= r_retries + 4'd1;
      end
      if (w_retry) begin
        r_backoff <= LP_BACKOFF_LAST;
      end else if ((r_state == S_BACKOFF) && (r_backoff != '0)) begin
        r_backoff <= r_backoff - 1'b1;
      end
`endif
    end
  end

  assign bus.cmd_ready_o = (r_state == S_IDLE);
  assign bus.rsp_valid_o = (r_state == S_RESP);
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_resp_o  = r_resp;
`ifdef UART_MEM_INITIATOR_RETRY_EN
  assign bus.rsp_retries_o = r_retries;
`else
  assign bus.rsp_retries_o = '0;
`endif

  assign mem_we_o    = r_mem_we;
  assign mem_re_o    = r_mem_re;
  assign mem_waddr_o = r_mem_waddr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_wstrb_o = r_mem_wstrb;
  assign mem_raddr_o = r_mem_raddr;

endmodule

// File: tb/tb_uart_mem_initiator.sv
// Directed testbench for uart_mem_initiator (both build variants).
module tb_uart_mem_initiator;

`ifdef UART_MEM_INITIATOR_RETRY_EN
  localparam int unsigned TB_MAX_RETRY = 2;
  localparam int unsigned TB_BACKOFF   = 4;
`else
  localparam int unsigned TB_MAX_RETRY = 15;
  localparam int unsigned TB_BACKOFF   = 16;
`endif

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        mem_we_o, mem_re_o;
  logic [5:0]  mem_waddr_o, mem_raddr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [1:0]  mem_wresp_i, mem_rresp_i;
  logic [31:0] mem_rdata_i;

  uart_mem_initiator_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  uart_mem_initiator #(
    .ADDR_WIDTH     (6),
    .DATA_WIDTH     (32),
    .MAX_RETRY      (TB_MAX_RETRY),
    .BACKOFF_CYCLES (TB_BACKOFF)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .bus         (bus.slave),
    .mem_we_o    (mem_we_o),
    .mem_waddr_o (mem_waddr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_wresp_i (mem_wresp_i),
    .mem_re_o    (mem_re_o),
    .mem_raddr_o (mem_raddr_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_rresp_i (mem_rresp_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: the first err_n attempts of a test return err_code.
  int          we_att = 0, re_att = 0;
  int          w_base = 0, r_base = 0;
  int          w_err_n = 0, r_err_n = 0;
  logic [1:0]  w_err_code = 2'b10, r_err_code = 2'b10;
  logic [31:0] rd_val = '0;

  always @(posedge clk_i) begin
    if (mem_we_o) we_att <= we_att + 1;
    if (mem_re_o) re_att <= re_att + 1;
  end
  assign mem_wresp_i = ((we_att - w_base) < w_err_n) ? w_err_code : 2'b00;
  assign mem_rresp_i = ((re_att - r_base) < r_err_n) ? r_err_code : 2'b00;
  assign mem_rdata_i = rd_val;

  // Pulse monitor
  int          we_seen = 0, re_seen = 0, both_seen = 0;
  time         we_t[$], re_t[$];
  logic [5:0]  last_waddr = '0, last_raddr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  always @(negedge clk_i) begin
    if (mem_we_o && mem_re_o) both_seen++;
    if (mem_we_o) begin
      we_seen++; we_t.push_back($time);
      last_waddr = mem_waddr_o; last_wdata = mem_wdata_o; last_wstrb = mem_wstrb_o;
    end
    if (mem_re_o) begin
      re_seen++; re_t.push_back($time);
      last_raddr = mem_raddr_o;
    end
  end

  time t_hs;

  function automatic int cyc_of(input time t);
    return int'((t - t_hs + 5) / 10);
  endfunction

  // Called at a negedge: drive command and wait for the accepting edge.
  task automatic drive_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    bus.cmd_write_i = wr; bus.cmd_addr_i = a; bus.cmd_wdata_i = d; bus.cmd_wstrb_i = s;
    bus.cmd_valid_i = 1'b1;
    for (k = 0; k < 50 && !bus.cmd_ready_o; k++) @(negedge clk_i);
    if (!bus.cmd_ready_o) check("cmd_ready_timeout", 0, 1);
    @(posedge clk_i);
    t_hs = $time;
    #1 bus.cmd_valid_i = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk_i);
    drive_cmd(wr, a, d, s);
  endtask

  task automatic take_rsp(input string tag, input int stall, input int exp_lat,
                          input logic [31:0] exp_rd, input logic [1:0] exp_rr, input logic [3:0] exp_rt);
    int k;
    int pulses;
    @(negedge clk_i);
    for (k = 0; k < 300 && !bus.rsp_valid_o; k++) @(negedge clk_i);
    if (!bus.rsp_valid_o) begin
      check({tag, "_rsp_timeout"}, 0, 1);
    end else begin
      check({tag, "_lat"},     64'(cyc_of($time)), 64'(exp_lat));
      check({tag, "_rdata"},   bus.rsp_rdata_o,   exp_rd);
      check({tag, "_resp"},    bus.rsp_resp_o,    exp_rr);
      check({tag, "_retries"}, bus.rsp_retries_o, exp_rt);
      pulses = we_seen + re_seen;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk_i);
        check({tag, "_stall_valid"}, bus.rsp_valid_o, 1);
        check({tag, "_stall_rdata"}, bus.rsp_rdata_o, exp_rd);
        check({tag, "_stall_resp"},  bus.rsp_resp_o,  exp_rr);
        check({tag, "_stall_cmdrdy"}, bus.cmd_ready_o, 0);
        check({tag, "_stall_waddr"}, mem_waddr_o, 0);
      end
      check({tag, "_stall_pulses"}, 64'(we_seen + re_seen), 64'(pulses));
      bus.rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1 bus.rsp_ready_i = 1'b0;
    end
  endtask

  task automatic new_test();
    w_base = we_att; r_base = re_att; w_err_n = 0; r_err_n = 0;
  endtask

  int wb, rb, seen;

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
    bus.cmd_wdata_i = '0;   bus.cmd_wstrb_i = '0;   bus.rsp_ready_i = 1'b0;

    // Reset state
    #12;
    check("rst_cmd_ready", bus.cmd_ready_o, 1);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    check("rst_rsp_resp",  bus.rsp_resp_o, 0);
    check("rst_retries",   bus.rsp_retries_o, 0);
    check("rst_mem_we",    mem_we_o, 0);
    check("rst_mem_re",    mem_re_o, 0);
    check("rst_waddr",     mem_waddr_o, 0);
    @(negedge clk_i); arst_ni = 1'b1;

    // T1: write 0x00 <- 0x21, OKAY
    new_test(); wb = we_seen; rb = re_seen;
    issue(1'b1, 6'h00, 32'h0000_0021, 4'hF);
    take_rsp("t1", 0, 2, 32'h0, 2'b00, 4'd0);
    check("t1_we_cnt", 64'(we_seen - wb), 1);
    check("t1_re_cnt", 64'(re_seen - rb), 0);
    check("t1_we_cyc", 64'(cyc_of(we_t[$])), 1);
    check("t1_waddr",  last_waddr, 6'h00);
    check("t1_wdata",  last_wdata, 32'h21);
    check("t1_wstrb",  last_wstrb, 4'hF);

    // T2: read 0x10 -> 0x28B1
    new_test(); wb = we_seen; rb = re_seen; rd_val = 32'h0000_28B1;
    issue(1'b0, 6'h10, 32'hFFFF_FFFF, 4'h0);
    take_rsp("t2", 0, 2, 32'h0000_28B1, 2'b00, 4'd0);
    check("t2_re_cnt", 64'(re_seen - rb), 1);
    check("t2_we_cnt", 64'(we_seen - wb), 0);
    check("t2_re_cyc", 64'(cyc_of(re_t[$])), 1);
    check("t2_raddr",  last_raddr, 6'h10);

`ifdef UART_MEM_INITIATOR_RETRY_EN
    // T3: write 0x14, two SLVERR then OKAY
    new_test(); wb = we_seen; w_err_n = 2; w_err_code = 2'b10;
    issue(1'b1, 6'h14, 32'hA5A5_0001, 4'h3);
    take_rsp("t3", 0, 12, 32'h0, 2'b00, 4'd2);
    check("t3_we_cnt", 64'(we_seen - wb), 3);
    check("t3_gap1",   64'(we_t[wb+1] - we_t[wb]), 50);
    check("t3_gap2",   64'(we_t[wb+2] - we_t[wb+1]), 50);
    check("t3_waddr",  last_waddr, 6'h14);

    // T4: read 0x18, always SLVERR, MAX_RETRY=2
    new_test(); rb = re_seen; r_err_n = 1000; r_err_code = 2'b10; rd_val = 32'hDEAD_BEEF;
    issue(1'b0, 6'h18, 32'h0, 4'h0);
    take_rsp("t4", 0, 12, 32'h0, 2'b10, 4'd2);
    check("t4_re_cnt", 64'(re_seen - rb), 3);
    check("t4_gap",    64'(re_t[rb+2] - re_t[rb+1]), 50);
`else
    // SLVERR reported directly, no retry
    new_test(); wb = we_seen; w_err_n = 1000; w_err_code = 2'b10;
    issue(1'b1, 6'h14, 32'hA5A5_0001, 4'h3);
    take_rsp("t3", 0, 2, 32'h0, 2'b10, 4'd0);
    check("t3_we_cnt", 64'(we_seen - wb), 1);

    // Non-00 response reported verbatim, read data suppressed
    new_test(); rb = re_seen; r_err_n = 1000; r_err_code = 2'b11; rd_val = 32'h1234_5678;
    issue(1'b0, 6'h18, 32'h0, 4'h0);
    take_rsp("t4", 0, 2, 32'h0, 2'b11, 4'd0);
    check("t4_re_cnt", 64'(re_seen - rb), 1);
`endif

    // T5: response held for 10 cycles, next command right after handshake
    new_test(); rd_val = 32'h5A5A_0F0F;
    issue(1'b0, 6'h04, 32'h0, 4'h0);
    take_rsp("t5", 10, 2, 32'h5A5A_0F0F, 2'b00, 4'd0);
    @(negedge clk_i);
    check("t5_next_ready", bus.cmd_ready_o, 1);
    new_test(); wb = we_seen;
    drive_cmd(1'b1, 6'h08, 32'h0000_00C3, 4'h1);
    take_rsp("t5b", 0, 2, 32'h0, 2'b00, 4'd0);
    check("t5b_we_cnt", 64'(we_seen - wb), 1);
    check("t5b_wdata",  last_wdata, 32'hC3);

    // T6: reset during an access (and during BACKOFF in the retry build)
    new_test(); w_err_n = 1000; w_err_code = 2'b10;
    issue(1'b1, 6'h0C, 32'h1111_2222, 4'hF);
    @(negedge clk_i);
    check("t6_pre_we", mem_we_o, 1);
`ifdef UART_MEM_INITIATOR_RETRY_EN
    @(negedge clk_i); @(negedge clk_i);
    check("t6_in_backoff_we", mem_we_o, 0);
`endif
    #1 arst_ni = 1'b0;
    #1;
    check("t6_we_drop",    mem_we_o, 0);
    check("t6_re_drop",    mem_re_o, 0);
    check("t6_waddr_drop", mem_waddr_o, 0);
    check("t6_wdata_drop", mem_wdata_o, 0);
    check("t6_rsp_valid",  bus.rsp_valid_o, 0);
    @(negedge clk_i); @(negedge clk_i);
    arst_ni = 1'b1;
    #1 check("t6_cmd_ready", bus.cmd_ready_o, 1);
    wb = we_seen; seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (bus.rsp_valid_o) seen++;
    end
    check("t6_no_rsp",   64'(seen), 0);
    check("t6_no_pulse", 64'(we_seen - wb), 0);

    check("never_both", 64'(both_seen), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule
